// File: rtl/fp_normalize_sequencer_pkg.sv
// Shared definitions for the FP post-subtraction normaliser.
//   MANT_W     : mantissa width (hidden + 23 fraction + guard/round/sticky)
//   LZ_W       : width of a leading-zero count / remaining-shift counter
//   NORM_EXP_W : exponent width of the bundled result type
//   norm_state_e : sequencer states
//   norm_res_t   : bundled normaliser result handed to the rounding stage
package fp_normalize_sequencer_pkg;

    localparam int MANT_W     = 27;
    localparam int LZ_W       = 5;
    localparam int NORM_EXP_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DETECT = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_DONE   = 2'd3
    } norm_state_e;

    typedef struct packed {
        logic                  sign;
        logic [NORM_EXP_W-1:0] exp;
        logic [MANT_W-1:0]     mant;
        logic                  zero;
        logic                  denorm;
    } norm_res_t;

endpackage

// File: rtl/fp_normalize_sequencer_lzd.sv
// Leading-zero detector for the 27-bit normaliser mantissa.
//   mant_i : mantissa to inspect
//   lz_o   : number of leading zeros, 0..27 (27 means all-zero input)
module fp_normalize_sequencer_lzd
    import fp_normalize_sequencer_pkg::*;
(
    input  logic [MANT_W-1:0] mant_i,
    output logic [LZ_W-1:0]   lz_o
);

    // Ascending scan: the last hit is the most significant set bit.
    always_comb begin
        lz_o = LZ_W'(MANT_W);
        for (int i = 0; i < MANT_W; i++) begin
            if (mant_i[i]) begin
                lz_o = LZ_W'(MANT_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_normalize_sequencer.sv
// Multi-cycle normaliser for effective-subtraction results. Captures one
// operand, counts leading zeros, left-shifts at most SHIFT_STEP places per
// cycle, adjusts the exponent (clamping to denormal) and presents the result.
//   clk, rst_n (sync, active-low), flush (sync abort)
//   in_valid/in_ready, in_sign, in_exp, in_mant   : operand handshake
//   out_valid/out_ready, out_sign, out_exp, out_mant, out_zero, out_denorm
//
// state  | meaning
// IDLE   | waiting for an operand, in_ready=1
// DETECT | leading-zero count, target shift and output exponent computed
// SHIFT  | mantissa shifted left by up to SHIFT_STEP per cycle
// DONE   | result presented, held until out_ready
module fp_normalize_sequencer
    import fp_normalize_sequencer_pkg::*;
#(
    parameter int EXP_W      = 8,
    parameter int SHIFT_STEP = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic              out_zero,
    output logic              out_denorm
);

    norm_state_e       state_q, state_d;
    logic              sign_q, sign_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [MANT_W-1:0] mant_q, mant_d;
    logic [LZ_W-1:0]   rem_q, rem_d;
    logic              zero_q, zero_d;
    logic              denorm_q, denorm_d;

    logic [LZ_W-1:0]   lz;
    logic [LZ_W-1:0]   shift_tgt;
    logic [LZ_W-1:0]   step;

    fp_normalize_sequencer_lzd u_lzd (
        .mant_i (mant_q),
        .lz_o   (lz)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            rem_q    <= '0;
            zero_q   <= 1'b0;
            denorm_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            rem_q    <= rem_d;
            zero_q   <= zero_d;
            denorm_q <= denorm_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        mant_d    = mant_q;
        rem_d     = rem_q;
        zero_d    = zero_q;
        denorm_d  = denorm_q;
        shift_tgt = '0;
        step      = '0;

        if (flush) begin
            // Abort wins over any handshake; captured data is simply abandoned.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        state_d  = ST_DETECT;
                        sign_d   = in_sign;
                        exp_d    = in_exp;
                        mant_d   = in_mant;
                        rem_d    = '0;
                        zero_d   = 1'b0;
                        denorm_d = 1'b0;
                    end
                end
                ST_DETECT: begin
                    if (lz == LZ_W'(MANT_W)) begin
                        zero_d = 1'b1;
                        exp_d  = '0;
                        mant_d = '0;
                    end else if (32'(exp_q) > 32'(lz)) begin
                        shift_tgt = lz;
                        exp_d     = exp_q - EXP_W'(lz);
                    end else begin
                        // Shift only as far as the exponent allows; exp 0 and
                        // exp 1 both land on the denormal scale unshifted.
                        shift_tgt = (exp_q == '0) ? '0 : LZ_W'(exp_q - EXP_W'(1));
                        exp_d     = '0;
                        denorm_d  = 1'b1;
                    end
                    if (shift_tgt == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        rem_d   = shift_tgt;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    step   = (32'(rem_q) < SHIFT_STEP) ? rem_q : LZ_W'(SHIFT_STEP);
                    mant_d = mant_q << step;
                    rem_d  = rem_q - step;
                    if (rem_d == '0) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign in_ready   = rst_n && (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE) && !flush;
    assign out_sign   = sign_q;
    assign out_exp    = exp_q;
    assign out_mant   = mant_q;
    assign out_zero   = zero_q;
    assign out_denorm = denorm_q;

endmodule

// File: tb/tb_fp_normalize_sequencer.sv
module tb_fp_normalize_sequencer;
    import fp_normalize_sequencer_pkg::*;

    localparam int EXP_W = 8;
    localparam int STEP  = 8;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, in_sign;
    logic [7:0]  in_exp, out_exp;
    logic [26:0] in_mant, out_mant;
    logic        out_valid, out_ready, out_sign, out_zero, out_denorm;

    fp_normalize_sequencer #(.EXP_W(EXP_W), .SHIFT_STEP(STEP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sign   (out_sign),
        .out_exp    (out_exp),
        .out_mant   (out_mant),
        .out_zero   (out_zero),
        .out_denorm (out_denorm)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    norm_res_t exp_q[$];
    int        lat_q[$];
    logic      bp_random = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Leading zeros from the bit length of the value.
    function automatic int lz_of(input logic [26:0] m);
        if (m == 27'd0) return 27;
        return 27 - $clog2(int'(m) + 1);
    endfunction

    task automatic model(input logic sign, input int e, input logic [26:0] m,
                         output norm_res_t r, output int k);
        int lz, s;
        lz = lz_of(m);
        r = '0;
        r.sign = sign;
        if (lz == 27) begin
            r.zero = 1'b1;
            s = 0;
        end else if (e > lz) begin
            s = lz;
            r.exp = 8'(e - lz);
        end else begin
            s = (e == 0) ? 0 : e - 1;
            r.denorm = 1'b1;
        end
        r.mant = (lz == 27) ? 27'd0 : m << s;
        k = (s + STEP - 1) / STEP;
    endtask

    task automatic push_expect(input logic sign, input int e, input logic [26:0] m);
        norm_res_t r;
        int k;
        model(sign, e, m, r, k);
        exp_q.push_back(r);
        lat_q.push_back(cyc + 1 + k);
    endtask

    function automatic logic [26:0] mk_mant(input int lz);
        logic [26:0] one, top, rnd;
        if (lz >= 27) return 27'd0;
        one = 27'd1;
        top = one << (26 - lz);
        rnd = 27'($urandom) & (top - 27'd1);
        return top | rnd;
    endfunction

    task automatic send(input logic sign, input int e, input logic [26:0] m,
                        input bit push, output int waited);
        @(negedge clk);
        in_valid = 1'b1;
        in_sign  = sign;
        in_exp   = 8'(e);
        in_mant  = m;
        waited   = 0;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) push_expect(sign, e, m);
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() > 0 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            lat_q.delete();
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (bp_random) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor / scoreboard
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [37:0] held = '0;
    always @(negedge clk) begin
        logic [37:0] cur;
        norm_res_t   e;
        cur = {out_sign, out_exp, out_mant, out_zero, out_denorm};
        if (out_valid) begin
            check("in_ready_while_valid", 64'(in_ready), 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'(cur), 64'd0 - 64'd1);
            end else begin
                if (!prev_valid) check("latency", 64'(cyc), 64'(lat_q[0]));
                if (prev_valid && !prev_ready) check("hold_stable", 64'(cur), 64'(held));
                if (out_ready) begin
                    e = exp_q.pop_front();
                    void'(lat_q.pop_front());
                    check("result", 64'(cur), 64'(e));
                end
            end
        end
        prev_valid = out_valid;
        prev_ready = out_ready;
        held       = cur;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int w;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sign = 1'b0;
        in_exp = '0; in_mant = '0; out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs", 64'({out_sign, out_exp, out_mant, out_zero, out_denorm}), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Directed cases
        send(1'b0, 100, 27'h4000000, 1, w);
        send(1'b0, 100, 27'h0000200, 1, w);
        send(1'b0, 10,  27'h0000001, 1, w);
        send(1'b1, 50,  27'h0000000, 1, w);
        send(1'b0, 0,   27'h0100000, 1, w);
        send(1'b1, 1,   27'h0000040, 1, w);
        drain();

        // Backpressure then back-to-back accept
        out_ready = 1'b0;
        send(1'b0, 100, 27'h0000200, 1, w);
        w = 0;
        while (!out_valid && w < 50) begin @(negedge clk); w++; end
        check("bp_valid_seen", 64'(out_valid), 64'd1);
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_sign = 1'b1; in_exp = 8'd30; in_mant = 27'h0012345;
        @(negedge clk);
        check("hs_cycle_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("ready_after_hs", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        push_expect(1'b1, 30, 27'h0012345);
        @(negedge clk);
        check("b2b_accepted", 64'(in_ready), 64'd0);
        drain();

        // Flush in the second SHIFT cycle
        send(1'b0, 100, 27'h0000200, 0, w);
        @(posedge clk);
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flush_idle", 64'(in_ready), 64'd1);
        repeat (8) begin
            @(negedge clk);
            check("flush_no_valid", 64'(out_valid), 64'd0);
        end

        // Reset in the second SHIFT cycle
        send(1'b1, 100, 27'h0000200, 0, w);
        @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_outputs", 64'({out_sign, out_exp, out_mant, out_zero, out_denorm}), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_release", 64'(in_ready), 64'd1);
        repeat (6) begin
            @(negedge clk);
            check("rst_no_valid", 64'(out_valid), 64'd0);
        end

        // Leading-zero sweep 0..27
        for (int lz = 0; lz <= 27; lz++) begin
            send(1'($urandom), 200, mk_mant(lz), 1, w);
        end
        drain();

        // Randomized traffic with random backpressure
        bp_random = 1'b1;
        for (int n = 0; n < 200; n++) begin
            int e;
            e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : int'($urandom_range(0, 255));
            send(1'($urandom), e, mk_mant(int'($urandom_range(0, 27))), 1, w);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        bp_random = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
